load_store_unit: RTL and testbench

Sits between the single-cycle datapath and data memory and turns the datapath's load/store request into a bus transaction. Handles byte/halfword/word sizing, big-endian byte lanes and load sign/zero extension, plus a wait-state handshake with a bounded timeout. The datapath stalls on `busy` until the one-cycle `done` pulse.

---
 rtl/load_store_unit.sv | 191 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: datapath request -> single big-endian bus cycle with wait-state timeout.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of force-aligning them.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  off_q, off_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic        misalign;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((size == 2'd1) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane steering from the live request; half/word ignore the low offset bits.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata;
    case (size)
      2'd0: begin
        be_calc    = 4'b1000 >> addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'd1: begin
        be_calc    = addr[1] ? 4'b0011 : 4'b1100;
        wdata_calc = {2{wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
      end
    endcase
  end

  // Load extraction uses the offset captured at acceptance, not the live address.
  always_comb begin
    byte_sel = mem_rdata[31:24];
    case (off_q)
      2'd0:    byte_sel = mem_rdata[31:24];
      2'd1:    byte_sel = mem_rdata[23:16];
      2'd2:    byte_sel = mem_rdata[15:8];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (size_q)
      2'd0:    load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'd1:    load_val = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    sext_d      = sext_q;
    off_d       = off_q;
    err_d       = 1'b0;
    rdata_d     = '0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d   = we;
          size_d = size;
          sext_d = sext;
          off_d  = addr[1:0];
          if (misalign) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d     = ACCESS;
            cnt_d       = 8'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = we;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = be_calc;
            mem_wdata_d = wdata_calc;
          end
        end
      end
      ACCESS: begin
        // A ready arriving on the last allowed cycle still wins over the timeout.
        if (mem_ready) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          rdata_d   = we_q ? 32'd0 : load_val;
        end else if (cnt_q == TimeoutCnt) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      sext_q      <= 1'b0;
      off_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      off_q       <= off_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == RESP);
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: main instance (TIMEOUT=16) plus a TIMEOUT=4 instance for abort cases.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0, t_req = 1'b0, we = 1'b0, sext = 1'b0, mem_ready = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;

  logic [31:0] rdata, mem_addr, mem_wdata, t_rdata, t_mem_addr, t_mem_wdata;
  logic        busy, done, err, mem_req, mem_we, t_busy, t_done, t_err, t_mem_req, t_mem_we;
  logic [3:0]  mem_be, t_mem_be;

  int n_chk = 0;
  int n_pass = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  load_store_unit #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(t_req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(t_rdata), .busy(t_busy), .done(t_done), .err(t_err),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_be(t_mem_be),
    .mem_wdata(t_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [1:0] s, input logic x,
                       input logic [31:0] a, input logic [31:0] d);
    we = w; size = s; sext = x; addr = a; wdata = d; req = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({rdata, busy, done, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0)
      $display("FAIL reset_outputs got rdata=%h busy=%b done=%b err=%b mem_req=%b be=%h addr=%h wdata=%h exp all zero",
               rdata, busy, done, err, mem_req, mem_be, mem_addr, mem_wdata); else n_pass++;
    tick(); tick();
    n_chk++; if ({busy, done, mem_req, t_busy, t_mem_req} !== 5'b0)
      $display("FAIL reset_held got busy=%b done=%b mem_req=%b t_busy=%b t_mem_req=%b exp 0", busy, done, mem_req, t_busy, t_mem_req); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word_store();
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    tick();
    n_chk++; if ({mem_req, mem_we, busy, done} !== 4'b1110)
      $display("FAIL ws_c1_ctl got req/we/busy/done=%b%b%b%b exp 1110", mem_req, mem_we, busy, done); else n_pass++;
    n_chk++; if (mem_addr !== 32'h10) $display("FAIL ws_addr got %h exp 00000010", mem_addr); else n_pass++;
    n_chk++; if (mem_be !== 4'b1111) $display("FAIL ws_be got %b exp 1111", mem_be); else n_pass++;
    n_chk++; if (mem_wdata !== 32'hDEADBEEF) $display("FAIL ws_wdata got %h exp deadbeef", mem_wdata); else n_pass++;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_chk++; if ({done, err, mem_req, busy} !== 4'b1001)
      $display("FAIL ws_c2 got done/err/mem_req/busy=%b%b%b%b exp 1001", done, err, mem_req, busy); else n_pass++;
    n_chk++; if (rdata !== 32'd0) $display("FAIL ws_rdata got %h exp 0", rdata); else n_pass++;
    req = 1'b0;
    tick();
    n_chk++; if ({done, busy} !== 2'b00) $display("FAIL ws_c3 got done/busy=%b%b exp 00", done, busy); else n_pass++;
  endtask

  task automatic test_byte_loads();
    logic [31:0] a_t [4]  = '{32'h21, 32'h23, 32'h20, 32'h22};
    logic        s_t [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0]  be_t [4] = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
    logic [31:0] r_t [4]  = '{32'hFFFFFF81, 32'h00000083, 32'h00000080, 32'hFFFFFF82};
    mem_rdata = 32'h80818283;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 2'd0, s_t[i], a_t[i], 32'h0);
      tick();
      n_chk++; if (mem_be !== be_t[i] || mem_addr !== 32'h20 || mem_we !== 1'b0)
        $display("FAIL bl%0d_lane got be=%b addr=%h we=%b exp be=%b addr=00000020 we=0", i, mem_be, mem_addr, mem_we, be_t[i]); else n_pass++;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      n_chk++; if (done !== 1'b1 || rdata !== r_t[i])
        $display("FAIL bl%0d_rdata got done=%b rdata=%h exp done=1 rdata=%h", i, done, rdata, r_t[i]); else n_pass++;
      req = 1'b0;
      tick();
    end
  endtask

  task automatic test_halfword();
    issue(1'b1, 2'd1, 1'b0, 32'h42, 32'hABCD1234);
    tick();
    n_chk++; if (mem_be !== 4'b0011 || mem_addr !== 32'h40)
      $display("FAIL hs_lane got be=%b addr=%h exp be=0011 addr=00000040", mem_be, mem_addr); else n_pass++;
    n_chk++; if (mem_wdata !== 32'h12341234) $display("FAIL hs_wdata got %h exp 12341234", mem_wdata); else n_pass++;
    mem_ready = 1'b1; tick(); mem_ready = 1'b0; req = 1'b0; tick();
    mem_rdata = 32'hFFFF1234;
    issue(1'b0, 2'd1, 1'b0, 32'h42, 32'h0);
    tick();
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    n_chk++; if (done !== 1'b1 || rdata !== 32'h00001234)
      $display("FAIL hl_low got done=%b rdata=%h exp done=1 rdata=00001234", done, rdata); else n_pass++;
    req = 1'b0; tick();
    mem_rdata = 32'h80001234;
    issue(1'b0, 2'd1, 1'b1, 32'h40, 32'h0);
    tick();
    n_chk++; if (mem_be !== 4'b1100) $display("FAIL hl_hi_be got %b exp 1100", mem_be); else n_pass++;
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    n_chk++; if (rdata !== 32'hFFFF8000) $display("FAIL hl_hi_sext got %h exp ffff8000", rdata); else n_pass++;
    req = 1'b0; tick();
  endtask

  task automatic test_wait_states();
    int req_cnt = 0, done_cyc = 0, busy_gap = 0;
    logic [31:0] rd = '0;
    logic er = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (mem_req) req_cnt++;
      if ((done_cyc == 0) && !busy) busy_gap++;
      if (done && done_cyc == 0) begin done_cyc = c; rd = rdata; er = err; req = 1'b0; end
      mem_ready = (c == 6);
    end
    mem_ready = 1'b0;
    n_chk++; if (req_cnt != 6) $display("FAIL ws_req_cycles got %0d exp 6", req_cnt); else n_pass++;
    n_chk++; if (done_cyc != 7) $display("FAIL ws_done_cycle got %0d exp 7", done_cyc); else n_pass++;
    n_chk++; if (busy_gap != 0) $display("FAIL ws_busy_gaps got %0d exp 0", busy_gap); else n_pass++;
    n_chk++; if (rd !== 32'hCAFEF00D || er !== 1'b0) $display("FAIL ws_result got rdata=%h err=%b exp cafef00d/0", rd, er); else n_pass++;
  endtask

  task automatic test_timeout();
    int req_cnt = 0, done_cyc = 0, n_done = 0;
    logic [31:0] rd = 'x;
    logic er = 1'b0;
    mem_rdata = 32'hFFFFFFFF;
    issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    req = 1'b0; t_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (t_mem_req) req_cnt++;
      if (t_done) begin n_done++; done_cyc = c; rd = t_rdata; er = t_err; t_req = 1'b0; end
    end
    n_chk++; if (done_cyc != 6 || n_done != 1) $display("FAIL to_done got cycle=%0d count=%0d exp cycle=6 count=1", done_cyc, n_done); else n_pass++;
    n_chk++; if (req_cnt != 5) $display("FAIL to_req_cycles got %0d exp 5", req_cnt); else n_pass++;
    n_chk++; if (er !== 1'b1 || rd !== 32'd0) $display("FAIL to_result got err=%b rdata=%h exp err=1 rdata=0", er, rd); else n_pass++;
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    n_chk++; if ({t_done, t_mem_req, t_busy, t_err} !== 4'b0)
      $display("FAIL to_late_ready got done/req/busy/err=%b%b%b%b exp 0000", t_done, t_mem_req, t_busy, t_err); else n_pass++;
    // Ready on the final allowed cycle completes normally.
    req_cnt = 0; done_cyc = 0; er = 1'b1; rd = '0;
    mem_rdata = 32'h0BADCAFE;
    t_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (t_mem_req) req_cnt++;
      if (t_done) begin done_cyc = c; rd = t_rdata; er = t_err; t_req = 1'b0; end
      mem_ready = (c == 5);
    end
    mem_ready = 1'b0;
    n_chk++; if (done_cyc != 6 || req_cnt != 5) $display("FAIL tb_edge_timing got done=%0d req_cycles=%0d exp 6/5", done_cyc, req_cnt); else n_pass++;
    n_chk++; if (er !== 1'b0 || rd !== 32'h0BADCAFE) $display("FAIL tb_edge_result got err=%b rdata=%h exp 0/0badcafe", er, rd); else n_pass++;
  endtask

  task automatic test_misalign();
    mem_rdata = 32'h11223344;
    issue(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
    tick();
`ifdef LSU_MISALIGN_TRAP_EN
    n_chk++; if ({done, err, busy, mem_req} !== 4'b1110)
      $display("FAIL ma_trap got done/err/busy/mem_req=%b%b%b%b exp 1110", done, err, busy, mem_req); else n_pass++;
    n_chk++; if (rdata !== 32'd0) $display("FAIL ma_trap_rdata got %h exp 0", rdata); else n_pass++;
    req = 1'b0; tick();
    n_chk++; if ({done, busy, mem_req} !== 3'b000) $display("FAIL ma_trap_after got done/busy/req=%b%b%b exp 000", done, busy, mem_req); else n_pass++;
`else
    n_chk++; if (mem_addr !== 32'h4 || mem_be !== 4'b1111 || mem_req !== 1'b1)
      $display("FAIL ma_align got addr=%h be=%b req=%b exp 00000004/1111/1", mem_addr, mem_be, mem_req); else n_pass++;
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    n_chk++; if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'h11223344)
      $display("FAIL ma_result got done=%b err=%b rdata=%h exp 1/0/11223344", done, err, rdata); else n_pass++;
    req = 1'b0; tick();
`endif
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 2'd0, 1'b0, 32'h61, 32'h000000A5);
    tick();
    n_chk++; if (mem_be !== 4'b0100 || mem_wdata !== 32'hA5A5A5A5)
      $display("FAIL bb_byte got be=%b wdata=%h exp 0100/a5a5a5a5", mem_be, mem_wdata); else n_pass++;
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    n_chk++; if (done !== 1'b1) $display("FAIL bb_done1 got %b exp 1", done); else n_pass++;
    mem_rdata = 32'h76543210;
    issue(1'b0, 2'd2, 1'b0, 32'h70, 32'h0);
    tick();
    n_chk++; if ({busy, mem_req} !== 2'b00) $display("FAIL bb_idle got busy/req=%b%b exp 00", busy, mem_req); else n_pass++;
    tick();
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h70 || mem_we !== 1'b0)
      $display("FAIL bb_second got req=%b addr=%h we=%b exp 1/00000070/0", mem_req, mem_addr, mem_we); else n_pass++;
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    n_chk++; if (rdata !== 32'h76543210) $display("FAIL bb_rdata got %h exp 76543210", rdata); else n_pass++;
    req = 1'b0; tick();
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 2'd2, 1'b0, 32'h50, 32'h12345678);
    tick();
    n_chk++; if (mem_req !== 1'b1) $display("FAIL rm_pre got mem_req=%b exp 1", mem_req); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({rdata, busy, done, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0)
      $display("FAIL rm_outputs got busy=%b mem_req=%b we=%b addr=%h be=%b wdata=%h exp all zero",
               busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata); else n_pass++;
    req = 1'b0;
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    n_chk++; if ({done, mem_req, busy, err} !== 4'b0)
      $display("FAIL rm_late_ready got done/req/busy/err=%b%b%b%b exp 0000", done, mem_req, busy, err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_loads();
    test_halfword();
    test_wait_states();
    test_timeout();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
